// File: rtl/phantom_clock.sv
`default_nettype none
// ============================================================================
// Module      : phantom_clock
// Description : DS1215-style phantom timekeeper gating TimeDisk's ROM/SRAM
//               select; unlocked by a 64-bit serial pattern on D[0].
// Revision    : 1.0 - initial release
// ============================================================================
module phantom_clock #(
    parameter int          TICK_DIV = 71591,
    parameter logic [63:0] PATTERN  = 64'h5CA33AC55CA33AC5
) (
    input  logic C7M,
    input  logic nRES,
    input  logic nCEI,
    input  logic nWE,
    input  logic DIN,
    output logic DOUT,
    output logic DOE,
    output logic RAMROMCSgb
);

    localparam int                 c_DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
    // 2000-01-01, Saturday (day 7), 00:00:00.00, oscillator running
    localparam logic [63:0]        c_POWER_UP = 64'h0001_0107_0000_0000;

    typedef enum logic [0:0] {
        ST_MATCH = 1'b0,
        ST_XFER  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [5:0]         r_cnt;
    logic [5:0]         w_cnt_nxt;
    logic [63:0]        r_shadow;
    logic [63:0]        w_shadow_nxt;
    logic               r_wr_seen;
    logic               w_wr_seen_nxt;
    logic [1:0]         r_ce_sync;
    logic               r_ces_d;
    logic               r_smp_we;
    logic               r_smp_din;
    logic [c_DIV_W-1:0] r_div;
    logic [63:0]        r_time = c_POWER_UP;
    logic               w_ces;
    logic               w_acc_end;
    logic               w_tick;
    logic               w_commit;

    function automatic logic [7:0] f_bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'h9)
            return {v[7:4] + 4'd1, 4'h0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] f_month_len(input logic [7:0] mon, input logic [7:0] yr);
        logic leap;
        // BCD year divisible by 4: even tens with units 0/4/8, odd tens with 2/6
        if (yr[4])
            leap = (yr[3:0] == 4'h2) || (yr[3:0] == 4'h6);
        else
            leap = (yr[3:0] == 4'h0) || (yr[3:0] == 4'h4) || (yr[3:0] == 4'h8);
        case (mon)
            8'h02:                      return leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic [63:0] f_tick(input logic [63:0] t);
        logic [63:0] n;
        logic [7:0]  v;
        logic        c;
        n = t;
        v = 8'h00;
        c = 1'b0;
        if (t[7:0] >= 8'h99) begin
            n[7:0] = 8'h00;
            c      = 1'b1;
        end else begin
            n[7:0] = f_bcd_inc(t[7:0]);
        end
        if (c) begin
            if (t[14:8] >= 7'h59) begin
                n[14:8] = 7'h00;
            end else begin
                v       = f_bcd_inc({1'b0, t[14:8]});
                n[14:8] = v[6:0];
                c       = 1'b0;
            end
        end
        if (c) begin
            if (t[23:16] >= 8'h59) begin
                n[23:16] = 8'h00;
            end else begin
                n[23:16] = f_bcd_inc(t[23:16]);
                c        = 1'b0;
            end
        end
        if (c) begin
            if (t[29:24] >= 6'h23) begin
                n[29:24] = 6'h00;
            end else begin
                v        = f_bcd_inc({2'b00, t[29:24]});
                n[29:24] = v[5:0];
                c        = 1'b0;
            end
        end
        if (c) begin
            n[34:32] = (t[34:32] >= 3'd7) ? 3'd1 : t[34:32] + 3'd1;
            if (t[47:40] >= f_month_len(t[55:48], t[63:56])) begin
                n[47:40] = 8'h01;
            end else begin
                n[47:40] = f_bcd_inc(t[47:40]);
                c        = 1'b0;
            end
        end
        if (c) begin
            if (t[55:48] >= 8'h12) begin
                n[55:48] = 8'h01;
            end else begin
                n[55:48] = f_bcd_inc(t[55:48]);
                c        = 1'b0;
            end
        end
        if (c)
            n[63:56] = (t[63:56] >= 8'h99) ? 8'h00 : f_bcd_inc(t[63:56]);
        return n;
    endfunction

    assign w_ces     = r_ce_sync[1];
    assign w_acc_end = w_ces & ~r_ces_d;
    assign w_tick    = (r_div == c_DIV_LAST);

    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            r_ce_sync <= 2'b11;
            r_ces_d   <= 1'b1;
            r_smp_we  <= 1'b1;
            r_smp_din <= 1'b0;
            r_state   <= ST_MATCH;
            r_cnt     <= 6'd0;
            r_shadow  <= 64'd0;
            r_wr_seen <= 1'b0;
            r_div     <= '0;
        end else begin
            r_ce_sync <= {r_ce_sync[0], nCEI};
            r_ces_d   <= w_ces;
            if (!w_ces) begin
                r_smp_we  <= nWE;
                r_smp_din <= DIN;
            end
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shadow  <= w_shadow_nxt;
            r_wr_seen <= w_wr_seen_nxt;
            if (w_commit || w_tick)
                r_div <= '0;
            else
                r_div <= r_div + c_DIV_W'(1);
        end
    end

    // Every control update waits for the end of an access, so the memory
    // gating never changes while a chip select is in progress.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shadow_nxt  = r_shadow;
        w_wr_seen_nxt = r_wr_seen;
        w_commit      = 1'b0;
        if (w_acc_end) begin
            case (r_state)
                ST_MATCH: begin
                    if (!r_smp_we && (r_smp_din == PATTERN[r_cnt])) begin
                        if (&r_cnt) begin
                            w_state_nxt  = ST_XFER;
                            w_cnt_nxt    = 6'd0;
                            w_shadow_nxt = r_time;
                        end else begin
                            w_cnt_nxt = r_cnt + 6'd1;
                        end
                    end else begin
                        w_cnt_nxt = 6'd0;
                    end
                end
                ST_XFER: begin
                    if (!r_smp_we) begin
                        w_shadow_nxt[r_cnt] = r_smp_din;
                        w_wr_seen_nxt       = 1'b1;
                    end
                    if (&r_cnt) begin
                        w_state_nxt   = ST_MATCH;
                        w_cnt_nxt     = 6'd0;
                        w_commit      = !r_smp_we && w_wr_seen_nxt;
                        w_wr_seen_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_MATCH;
                    w_cnt_nxt   = 6'd0;
                end
            endcase
        end
    end

    // Live time survives nRES; a commit takes priority over a coincident tick.
    always_ff @(posedge C7M) begin
        if (w_commit)
            r_time <= w_shadow_nxt;
        else if (w_tick && !r_time[37])
            r_time <= f_tick(r_time);
    end

    assign RAMROMCSgb = !nCEI && (r_state != ST_XFER);
    assign DOE        = !nCEI && nWE && (r_state == ST_XFER);
    assign DOUT       = r_shadow[r_cnt];

endmodule
`default_nettype wire

// File: doc/phantom_clock.md
Name: phantom_clock

Overview:
- Emulates the DS1215 "phantom" timekeeper that sits between TimeDisk's nRAMROMCS output and the ROM/SRAM chip selects, and produces RAMROMCSgb.
- Software unlocks the clock by writing a 64-bit recognition pattern, one D[0] bit per chip-select access.
- The next 64 accesses transfer the BCD time serially, and memory is deselected during those accesses.
- The block keeps time itself from C7M.

Parameters:
- TICK_DIV, 71591: C7M cycles per 1/100 s tick (7.1591 MHz / 100).
- PATTERN, 64'h5CA33AC55CA33AC5: recognition bit sequence; bit i is compared on access i.

Ports:
- C7M  in  1  system clock; all logic on posedge.
- nRES  in  1  asynchronous active-low reset.
- nCEI  in  1  chip-select input from TimeDisk nRAMROMCS, active low.
- nWE  in  1  6502 R/W; low = write.
- DIN  in  1  Apple II D[0].
- DOUT  out  1  time bit driven onto D[0].
- DOE  out  1  D[0] output enable.
- RAMROMCSgb  out  1  gated memory enable (active high), to TimeDisk.

Behaviour:
Access detection:
- nCEI passes through a 2-flop synchronizer to give ceS.
- An access ends on the ceS 0->1 transition.
- nWE and DIN are sampled every cycle while ceS=0. The last sample before the rise is the access's type and bit.
- Timing requirement on the bus: nCEI low for at least 3 C7M cycles, high for at least 2.

State machine (all state updates happen only on an access end):
- MATCH, bit counter cnt 0..63.
  - Write with DIN==PATTERN[cnt] -> cnt+1.
  - Write with a mismatching bit, or any read -> cnt=0 (no partial re-match).
  - Write matching at cnt=63 -> go to XFER, cnt=0, and copy live time into shadow[63:0].
- XFER, cnt 0..63.
  - Read -> no register change; the bit was driven from shadow[cnt] during the access.
  - Write -> shadow[cnt]=DIN and set the flag wr_seen.
  - cnt=63 -> return to MATCH, cnt=0. If the access at cnt=63 is a write, commit shadow into live time, clear the tick divider, and clear wr_seen. If it is a read, wr_seen is discarded.

Outputs:
- RAMROMCSgb = !nCEI && state!=XFER. This is a combinational path from the raw nCEI pin.
- DOE = !nCEI && nWE && state==XFER.
- DOUT = shadow[cnt].
- The state register only changes while ceS=1, so the gating is glitch-free within an access.

Time register (LSB first, byte k = bits 8k+7:8k, all BCD):
- B0 hundredths 00-99.
- B1 seconds 00-59 (bit7 stored, no effect).
- B2 minutes 00-59.
- B3 hours 00-23; 24-hour mode only, bit7 stored, no effect.
- B4[2:0] day-of-week 1-7; B4[5] OSC, where 1 stops ticking; other bits stored.
- B5 date 01-28/29/30/31.
- B6 month 01-12.
- B7 year 00-99.

Timekeeping:
- The divider counts 0..TICK_DIV-1; wrap = tick.
- On tick with OSC=0, increment with BCD carry chain: hundredths -> seconds -> minutes -> hours -> day and date together.
- Day-of-week wraps 7->1.
- Date wraps past month length to 01 and carries into month. Month lengths: 31/30 fixed per month; Feb = 29 if year mod 4 == 0, else 28.
- Month wraps 12->01 and carries into year; year wraps 99->00.
- Tick and commit in the same cycle: commit wins.

Reset:
- nRES low -> MATCH, cnt=0, wr_seen=0, divider=0, shadow=0. Outputs then are RAMROMCSgb = !nCEI, DOE=0, DOUT=0.
- Live time and OSC are NOT reset by nRES. Power-up value is 2000-01-01 Sat (day 7) 00:00:00.00 with OSC=0.
- Reset mid-XFER aborts the transfer without commit.

Test Plan:
1. Write the 64 PATTERN bits, then 64 reads -> RAMROMCSgb is high during all pattern writes and low during all 64 reads. DOE is high only on those reads, and the DOUT sequence equals the time snapshot taken at the match. The 129th access has RAMROMCSgb high again.
2. Write 40 matching bits, 1 read, then 64 PATTERN writes -> XFER is entered only after the final 64. The 41st matching write alone does not unlock.
3. Unlock, write 64 bits encoding 03-02-28 day 5 23:59:59.99, then run 1 tick -> reading back gives 03-03-01 day 6 00:00:00.00.
4. Set year 04, Feb 28 23:59:59.99, then 1 tick -> Feb 29. Set Feb 29 23:59:59.99 -> next tick gives Mar 01. Set Dec 31 99 -> year rolls to 00, Jan 01.
5. Unlock, 30 writes with a changed time, assert nRES, then re-unlock and read -> the original time (advanced by elapsed ticks) is returned with no commit. Memory is enabled immediately after reset.
6. Set OSC=1 via commit, wait 5*TICK_DIV cycles -> time unchanged. Clear OSC -> counting resumes at the next divider wrap.
